// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Op-code and FSM-state encodings shared by the multi-cycle ALU.
//            The 4-bit legacy op encodings are preserved unchanged.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU operation select codes; any code not listed decodes as NOR
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1111;

  // Handshake FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_iter
// Purpose  : Iterative shift-add multiplier producing the low WIDTH bits of
//            a*b (unsigned) in WIDTH steps. done is asserted during the final
//            step and product then presents the completed accumulator value,
//            so the caller can capture it on the same edge that ends the op.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last_step = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_acc_next;

  // Accumulator value after the current step's partial product
  always_comb begin
    w_acc_next = r_acc + (r_b_sh[0] ? r_a_sh : '0);
  end

  // Operand shift registers, accumulator and step counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc  <= w_acc_next;
      r_a_sh <= r_a_sh << 1;
      r_b_sh <= r_b_sh >> 1;
      r_cnt  <= r_cnt + 1'b1;
      if (r_cnt == c_last_step) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == c_last_step);
  assign product = w_acc_next;

endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/alu_mc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_pipe
// Purpose  : Registered execute-stage ALU with valid/ready handshakes. Single
//            cycle logic/arith/shift ops, iterative WIDTH-cycle MUL, and
//            N/Z/C/V flags captured alongside the result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int c_msb = WIDTH - 1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_shamt;
  logic             w_ovf_add;
  logic             w_ovf_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [WIDTH-1:0] w_load_val;
  logic             w_load_c;
  logic             w_load_v;

  logic [WIDTH-1:0] r_result;
  logic             r_out_valid;
  logic             r_zero;
  logic             r_negative;
  logic             r_carry;
  logic             r_overflow;

  assign w_accept    = in_valid && w_in_ready;
  assign w_mul_start = w_accept && (alu_op == ALU_MUL);

  alu_mul_iter #(
    .WIDTH   (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (reset),
    .start   (w_mul_start),
    .a       (a),
    .b       (b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  // Single-cycle op mux; SUB and SLT share the a + ~b + 1 adder
  always_comb begin
    w_sum     = {1'b0, a} + {1'b0, b};
    w_diff    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    w_shamt   = b[SHW-1:0];
    w_ovf_add = (a[c_msb] == b[c_msb]) && (w_sum[c_msb]  != a[c_msb]);
    w_ovf_sub = (a[c_msb] != b[c_msb]) && (w_diff[c_msb] != a[c_msb]);
    w_res     = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    case (alu_op)
      ALU_AND: w_res = a & b;
      ALU_OR:  w_res = a | b;
      ALU_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_ovf_add;
      end
      ALU_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = w_ovf_sub;
      end
      ALU_SLT: begin
        // Signed less-than: sign of the difference corrected by overflow
        w_res = {{(WIDTH-1){1'b0}}, w_diff[c_msb] ^ w_ovf_sub};
        w_c   = w_diff[WIDTH];
      end
      ALU_SLL: w_res = a << w_shamt;
      ALU_SRL: w_res = a >> w_shamt;
      ALU_SRA: w_res = $unsigned($signed(a) >>> w_shamt);
      ALU_MUL: w_res = '0;
      default: w_res = ~(a | b);
    endcase
  end

  // Select what the output register captures: multiplier product or op mux
  always_comb begin
    w_load_val = w_mul_done ? w_mul_product : w_res;
    w_load_c   = w_mul_done ? 1'b0 : w_c;
    w_load_v   = w_mul_done ? 1'b0 : w_v;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start)                 w_state_next = ST_MUL;
      ST_MUL:  if (w_mul_done)                  w_state_next = ST_HOLD;
      ST_HOLD: if (r_out_valid && out_ready)    w_state_next = ST_IDLE;
      default:                                  w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only in IDLE when the output slot is free or draining
  always_comb begin
    w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  end

  // Output register: load on single-cycle accept or MUL completion, else drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
    end else if ((w_accept && !w_mul_start) || w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_load_val;
      r_zero      <= (w_load_val == '0);
      r_negative  <= w_load_val[c_msb];
      r_carry     <= w_load_c;
      r_overflow  <= w_load_v;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign busy      = w_mul_busy;

endmodule : alu_mc_pipe
`default_nettype wire

// File: tb/tb_alu_mc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc_pipe
// Purpose  : Self-checking bench for alu_mc_pipe. Directed vectors on a
//            64-bit instance plus a randomly stalled 8-bit instance, both
//            checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc_pipe;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] a, b, result;
  logic [3:0]  alu_op;
  logic        zero, negative, carry, overflow, busy;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, result8;
  logic [3:0]  alu_op8;
  logic        zero8, negative8, carry8, overflow8, busy8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [67:0] exp64[$];
  logic [67:0] exp8[$];

  always #5 clk = ~clk;

  alu_mc_pipe #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .busy(busy)
  );

  alu_mc_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .alu_op(alu_op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .zero(zero8), .negative(negative8), .carry(carry8),
    .overflow(overflow8), .busy(busy8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model at width w: returns {result[63:0], Z, N, C, V}
  function automatic logic [67:0] model(input int w, input logic [3:0] op,
                                        input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, aa, bb, r, sa, sb;
    logic [64:0] full;
    logic        c, v;
    int          sh;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    aa   = a_in & mask;
    bb   = b_in & mask;
    sa   = aa[w-1] ? (aa | ~mask) : aa;
    sb   = bb[w-1] ? (bb | ~mask) : bb;
    sh   = int'(bb[6:0]) % w;
    r = '0; c = 1'b0; v = 1'b0; full = '0;
    case (op)
      4'b0000: r = aa & bb;
      4'b0001: r = aa | bb;
      4'b0010: begin
        full = {1'b0, aa} + {1'b0, bb};
        r = full[63:0] & mask; c = full[w];
        v = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
      end
      4'b0110: begin
        full = {1'b0, aa} + {1'b0, ~bb & mask} + 65'd1;
        r = full[63:0] & mask; c = full[w];
        v = (aa[w-1] != bb[w-1]) && (r[w-1] != aa[w-1]);
      end
      4'b0111: begin
        full = {1'b0, aa} + {1'b0, ~bb & mask} + 65'd1;
        c = full[w];
        r = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
      end
      4'b0011: r = (aa << sh) & mask;
      4'b0100: r = aa >> sh;
      4'b0101: r = $unsigned($signed(sa) >>> sh) & mask;
      4'b1000: r = (aa * bb) & mask;
      default: r = ~(aa | bb) & mask;
    endcase
    return {r, (r == 64'd0), r[w-1], c, v};
  endfunction

  // Scoreboard: queue expectations on accept, compare on every output transfer,
  // and require held outputs to stay stable while stalled
  logic        hold64 = 1'b0, hold8 = 1'b0;
  logic [67:0] prev64, prev8;
  always @(negedge clk) begin
    logic [67:0] e;
    if (reset) begin
      exp64.delete(); exp8.delete();
      hold64 = 1'b0; hold8 = 1'b0;
    end else begin
      if (hold64) begin
        chk("stall64_valid", {63'd0, out_valid}, 64'd1);
        chk("stall64_result", result, prev64[67:4]);
        chk("stall64_flags", {60'd0, zero, negative, carry, overflow}, {60'd0, prev64[3:0]});
      end
      if (hold8) begin
        chk("stall8_valid", {63'd0, out_valid8}, 64'd1);
        chk("stall8_out", {52'd0, result8, zero8, negative8, carry8, overflow8},
            {52'd0, prev8[11:4], prev8[3:0]});
      end
      if (in_valid && in_ready)   exp64.push_back(model(64, alu_op, a, b));
      if (in_valid8 && in_ready8) exp8.push_back(model(8, alu_op8, {56'd0, a8}, {56'd0, b8}));
      if (out_valid && out_ready) begin
        if (exp64.size() == 0) chk("unexpected_out64", 64'd1, 64'd0);
        else begin
          e = exp64.pop_front();
          chk("model64_result", result, e[67:4]);
          chk("model64_flags", {60'd0, zero, negative, carry, overflow}, {60'd0, e[3:0]});
        end
      end
      if (out_valid8 && out_ready8) begin
        if (exp8.size() == 0) chk("unexpected_out8", 64'd1, 64'd0);
        else begin
          e = exp8.pop_front();
          chk("model8_result", {56'd0, result8}, e[67:4]);
          chk("model8_flags", {60'd0, zero8, negative8, carry8, overflow8}, {60'd0, e[3:0]});
        end
      end
      hold64 = out_valid && !out_ready;
      prev64 = {result, zero, negative, carry, overflow};
      hold8  = out_valid8 && !out_ready8;
      prev8  = {56'd0, result8, zero8, negative8, carry8, overflow8};
    end
  end

  // Present one op to the 64-bit instance; returns one cycle after acceptance
  task automatic send(input logic [3:0] op, input logic [63:0] va, input logic [63:0] vb);
    int n;
    in_valid = 1'b1; alu_op = op; a = va; b = vb;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_n, ir_bad, n;
    reset = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; alu_op = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; alu_op8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_flags", {59'd0, zero, negative, carry, overflow, busy}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ADD wrap to zero, single-cycle latency
    send(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("add_valid_lat1", {63'd0, out_valid}, 64'd1);
    chk("add_result", result, 64'd0);
    chk("add_zcnv", {60'd0, zero, carry, negative, overflow}, {60'd0, 4'b1100});

    // SUB signed overflow
    send(4'b0110, 64'h8000_0000_0000_0000, 64'd1);
    chk("sub_result", result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_vcn", {61'd0, overflow, carry, negative}, {61'd0, 3'b110});

    // SRA, SLT, undefined code -> NOR
    send(4'b0101, 64'h8000_0000_0000_0000, 64'd63);
    chk("sra_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sra_neg", {63'd0, negative}, 64'd1);
    send(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    chk("slt_result", result, 64'd1);
    send(4'b1111, 64'd0, 64'd0);
    chk("nor_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    send(4'b0011, 64'h0000_0000_0000_00F1, 64'd68);
    chk("sll_mod_result", result, 64'h0000_0000_0000_0F10);

    // MUL latency, busy duration, in_ready low until drained
    @(posedge clk); #1;
    send(4'b1000, 64'd12345, 64'd6789);
    lat = 1; busy_n = 0; ir_bad = 0;
    while (!out_valid && lat < 200) begin
      busy_n += int'(busy);
      if (in_ready) ir_bad++;
      @(posedge clk); #1; lat++;
    end
    chk("mul_latency", 64'(lat), 64'd65);
    chk("mul_busy_cycles", 64'(busy_n), 64'd64);
    chk("mul_in_ready_low", 64'(ir_bad), 64'd0);
    chk("mul_result", result, 64'd83810205);
    chk("mul_hold_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("mul_drained_in_ready", {63'd0, in_ready}, 64'd1);

    // Output stall: result held, no accept, release lets next op in
    out_ready = 1'b0;
    send(4'b0010, 64'd5, 64'd7);
    in_valid = 1'b1; alu_op = 4'b0001; a = 64'hF0; b = 64'h0F;
    for (int i = 0; i < 5; i++) begin
      chk("stall_result", result, 64'd12);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release_next_result", result, 64'hFF);

    // Reset in the middle of a MUL
    @(posedge clk); #1;
    send(4'b1000, 64'd3, 64'd5);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_mul_state", {62'd0, out_valid, busy}, 64'd0);
    chk("rst_mid_mul_result", result, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send(4'b0010, 64'd3, 64'd4);
    chk("post_reset_add", result, 64'd7);
    @(posedge clk); #1;

    // 8-bit instance: random ops with random input/output stalls
    for (int i = 0; i < 600; i++) begin
      in_valid8  = ($urandom_range(0, 2) != 0);
      a8         = 8'($urandom);
      b8         = 8'($urandom);
      alu_op8    = 4'($urandom_range(0, 15));
      out_ready8 = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    n = 0;
    while ((exp8.size() != 0 || exp64.size() != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending", 64'(exp8.size() + exp64.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_mc_pipe
`default_nettype wire
